// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register offsets and the pin limit.
package gpio_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [2:0] GPIO_DATA_OUT = 3'd0;
  localparam logic [2:0] GPIO_DIR      = 3'd1;
  localparam logic [2:0] GPIO_DATA_IN  = 3'd2;
  localparam logic [2:0] GPIO_SET      = 3'd3;
  localparam logic [2:0] GPIO_CLR      = 3'd4;
  localparam logic [2:0] GPIO_TOG      = 3'd5;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd6;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd7;

  // Cycles during which edge detection is masked after reset.
  function automatic logic [2:0] warm_cycles(input int sync_stages);
    return 3'(sync_stages + 1);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser for the asynchronous pad inputs; every stage resets to 0.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

  // Shift the pad sample one stage deeper each cycle.
  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], async_in};
  end

  // Synchroniser register chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction, atomic set/clear/toggle, synchronised inputs
// and sticky rising-edge interrupt status with a post-reset warm-up mask.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] WARM_CYCLES = warm_cycles(SYNC_STAGES);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       warm_cnt_q, warm_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] wbits_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rise_s;
  logic [31:0]      rd_word_s;
  logic             wr_s;
  logic             rd_s;
  logic             warm_done_s;
  logic             wdata_unused_s;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_in),
    .sync_out (sync_s)
  );

  assign wr_s           = sel & we;
  assign rd_s           = sel & ~we;
  assign wbits_s        = wdata[WIDTH-1:0];
  assign wdata_unused_s = ^wdata;
  assign warm_done_s    = (warm_cnt_q == WARM_CYCLES);

  // Edge detection on the synchronised pins, masked until the chain has settled.
  always_comb begin
    prev_d = sync_s;
    rise_s = sync_s & ~prev_q & {WIDTH{warm_done_s}};
    if (warm_done_s) begin
      warm_cnt_d = warm_cnt_q;
    end else begin
      warm_cnt_d = warm_cnt_q + 3'd1;
    end
  end

  // Register write decode; a fresh edge overrides a same-cycle W1C on the same bit.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    w1c_s      = '0;
    if (wr_s) begin
      case (addr)
        GPIO_DATA_OUT: data_out_d = wbits_s;
        GPIO_DIR:      dir_d      = wbits_s;
        GPIO_SET:      data_out_d = data_out_q | wbits_s;
        GPIO_CLR:      data_out_d = data_out_q & ~wbits_s;
        GPIO_TOG:      data_out_d = data_out_q ^ wbits_s;
        GPIO_IRQ_EN:   irq_en_d   = wbits_s;
        GPIO_IRQ_STAT: w1c_s      = wbits_s;
        default:       w1c_s      = '0;
      endcase
    end else begin
      w1c_s = '0;
    end
    irq_stat_d = (irq_stat_q & ~w1c_s) | rise_s;
  end

  // Read mux, registered read data/valid and interrupt level.
  always_comb begin
    rd_word_s = '0;
    case (addr)
      GPIO_DATA_OUT: rd_word_s[WIDTH-1:0] = data_out_q;
      GPIO_DIR:      rd_word_s[WIDTH-1:0] = dir_q;
      GPIO_DATA_IN:  rd_word_s[WIDTH-1:0] = sync_s;
      GPIO_IRQ_EN:   rd_word_s[WIDTH-1:0] = irq_en_q;
      GPIO_IRQ_STAT: rd_word_s[WIDTH-1:0] = irq_stat_q;
      default:       rd_word_s = '0;
    endcase
    if (rd_s) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = rdata_q;
    end
    rvalid_d = rd_s;
    irq_d    = |(irq_stat_q & irq_en_q);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      warm_cnt_q <= 3'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      warm_cnt_q <= warm_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (WIDTH=8, SYNC_STAGES=2): reference model plus directed tests.
module tb_gpio_ctrl;

  localparam int W = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel;
  logic          we;
  logic [2:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int n_compared = 0;
  int n_mismatch = 0;

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad samples are kept as a delay line: the synchronised value is the sample taken
  // S edges ago; a rising edge compares it with the sample one edge older.
  logic [W-1:0] m_out, m_dir, m_en, m_stat;
  logic [W-1:0] m_hist [0:S];
  logic [31:0]  m_rdata;
  logic         m_rvalid, m_irq;
  int           m_age;
  bit           model_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [W-1:0] rise, wb, nstat;
    logic [31:0]  rv;
    if (rst) begin
      m_out = '0; m_dir = '0; m_en = '0; m_stat = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0; m_age = 0;
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      model_ok = 1'b1;
    end else begin
      rise = (m_age > S) ? (m_hist[S-1] & ~m_hist[S]) : '0;
      m_irq = |(m_stat & m_en);
      m_rvalid = sel && !we;
      if (sel && !we) begin
        rv = 32'd0;
        case (addr)
          3'd0: rv = {24'd0, m_out};
          3'd1: rv = {24'd0, m_dir};
          3'd2: rv = {24'd0, m_hist[S-1]};
          3'd6: rv = {24'd0, m_en};
          3'd7: rv = {24'd0, m_stat};
          default: rv = 32'd0;
        endcase
        m_rdata = rv;
      end
      wb = wdata[W-1:0];
      nstat = m_stat | rise;
      if (sel && we) begin
        case (addr)
          3'd0: m_out = wb;
          3'd1: m_dir = wb;
          3'd3: m_out = m_out | wb;
          3'd4: m_out = m_out & ~wb;
          3'd5: m_out = m_out ^ wb;
          3'd6: m_en  = wb;
          3'd7: nstat = (m_stat & ~wb) | rise;
          default: ;
        endcase
      end
      m_stat = nstat;
      for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = gpio_in;
      if (m_age < 1000) m_age++;
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_gpio_out", {24'd0, gpio_out}, {24'd0, m_out});
      check("m_gpio_oe",  {24'd0, gpio_oe},  {24'd0, m_dir});
      check("m_irq",      {31'd0, irq},      {31'd0, m_irq});
      check("m_rvalid",   {31'd0, rvalid},   {31'd0, m_rvalid});
      check("m_rdata",    rdata,             m_rdata);
    end
  end

  // ---------------- bus tasks (called and returning at a negedge) ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
  endtask

  initial begin : watchdog
    #200000;
    n_mismatch++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] v;
    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0; gpio_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: all registers read zero after reset
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), v);
      check($sformatf("t1_rd%0d", a), v, 32'd0);
    end

    // 2: A5 | SET(upper bits ignored) 0F -> AF, CLR 80 -> 2F, TOG 03 -> 2C
    bus_write(3'd0, 32'h0000_00A5);
    bus_write(3'd3, 32'hFFFF_FF0F);
    bus_write(3'd4, 32'h0000_0080);
    bus_write(3'd5, 32'h0000_0003);
    check("t2_gpio_out", {24'd0, gpio_out}, 32'h0000_002C);
    bus_read(3'd0, v);
    check("t2_data_out", v, 32'h0000_002C);

    // 3: DIR write truncated to WIDTH
    bus_write(3'd1, 32'hFFFF_FFFF);
    check("t3_gpio_oe", {24'd0, gpio_oe}, 32'h0000_00FF);
    bus_read(3'd1, v);
    check("t3_dir", v, 32'h0000_00FF);

    // 4: pins high through reset raise no status; bit 3 rise later does
    rst = 1'b1; gpio_in = 8'hF7;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    bus_read(3'd7, v);
    check("t4_stat_warm", v, 32'd0);
    bus_read(3'd2, v);
    check("t4_din_init", v, 32'h0000_00F7);
    gpio_in = 8'hFF;
    @(negedge clk);
    bus_read(3'd2, v);
    check("t4_din_early", v, 32'h0000_00F7);
    bus_read(3'd2, v);
    check("t4_din_sync", v, 32'h0000_00FF);
    bus_read(3'd7, v);
    check("t4_stat", v, 32'h0000_0008);
    check("t4_irq_off", {31'd0, irq}, 32'd0);
    bus_write(3'd6, 32'h0000_0008);
    check("t4_irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("t4_irq_on", {31'd0, irq}, 32'd1);

    // 5: W1C coinciding with a new rise on bit 3 leaves it set
    gpio_in = 8'hF7;
    repeat (4) @(negedge clk);
    gpio_in = 8'hFF;
    repeat (2) @(negedge clk);
    bus_write(3'd7, 32'h0000_0008);
    bus_read(3'd7, v);
    check("t5_stat_kept", v, 32'h0000_0008);
    bus_write(3'd7, 32'h0000_0008);
    check("t5_irq_lag", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("t5_irq_drop", {31'd0, irq}, 32'd0);
    bus_read(3'd7, v);
    check("t5_stat_clr", v, 32'd0);

    // 6: reset during a read drops it and clears everything
    sel = 1'b1; we = 1'b0; addr = 3'd0; rst = 1'b1;
    @(negedge clk);
    check("t6_rvalid", {31'd0, rvalid}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    check("t6_gpio_out", {24'd0, gpio_out}, 32'd0);
    check("t6_gpio_oe", {24'd0, gpio_oe}, 32'd0);
    check("t6_rdata", rdata, 32'd0);
    sel = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(3'd7, v);
    check("t6_stat", v, 32'd0);
    bus_read(3'd0, v);
    check("t6_data_out", v, 32'd0);
    bus_read(3'd1, v);
    check("t6_dir", v, 32'd0);
    bus_read(3'd6, v);
    check("t6_irq_en", v, 32'd0);
    repeat (2) @(negedge clk);

    summary();
    $finish;
  end

endmodule
